result_drain: RTL
=================

RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have parameter RESULT_WIDTH, default 16: width of a result word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: result-memory address width.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse to begin a drain; ignored while busy.
REQ-006 SHALL have port base_addr, input, ADDR_WIDTH: first address to read; sampled on start.
REQ-007 SHALL have port word_count, input, ADDR_WIDTH+1: number of words to read; sampled on start.
REQ-008 SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when the last word has been accepted downstream.
REQ-010 SHALL have port addrO, output, ADDR_WIDTH: read address to the result-memory host port.
REQ-011 SHALL have port dataO, input, RESULT_WIDTH: read data, valid exactly one cycle after addrO.
REQ-012 SHALL have port out_valid, output, 1: out_data holds a word.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts; a transfer happens when out_valid and out_ready are both high.
REQ-014 SHALL have port out_data, output, RESULT_WIDTH: streamed result word.

Function
REQ-015 SHALL implement states IDLE, READ, FLUSH, DONE.
REQ-016 IDLE: start moves to READ, latches base_addr and word_count, and clears the issue counter; when word_count is 0, start moves to DONE instead.
REQ-017 READ: issue one read per cycle when (fifo occupancy + reads in flight) < 2; addrO = base + issued count; address wraps modulo 2^ADDR_WIDTH.
REQ-018 READ moves to FLUSH in the cycle after the issue counter reaches word_count.
REQ-019 FLUSH moves to DONE when the FIFO is empty and no read is in flight.
REQ-020 DONE asserts done for exactly one cycle and then returns to IDLE.
REQ-021 dataO SHALL be written into a 2-entry FIFO in the cycle after its read was issued; the FIFO SHALL never overflow.
REQ-022 Words SHALL be output in address order, without loss or duplication, under any out_ready pattern.
REQ-023 While out_valid is high and out_ready is low, out_data SHALL hold stable.
REQ-024 With out_ready held high, throughput SHALL be one word per cycle, and first out_valid SHALL occur 2 cycles after start.
REQ-025 start arriving in the DONE cycle or while busy SHALL be ignored.
REQ-026 When addrO is not issuing, it SHALL hold its last value.

Reset
REQ-027 rst SHALL force IDLE, empty the FIFO, and cancel in-flight reads.
REQ-028 During rst, out_valid=0, busy=0, done=0, addrO=0, out_data=0.
REQ-029 rst mid-drain SHALL abort the drain; no done pulse is produced and no stale word appears after reset.

Configuration
REQ-030 When RESULT_DRAIN_TLAST_EN is defined, the block SHALL add output out_last (1 bit), high together with out_valid on the final word of a drain only.
REQ-031 When RESULT_DRAIN_TLAST_EN is undefined, out_last and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-032 The state enumeration and the default widths SHALL live in the shared package systolic_pkg.
REQ-033 The 2-entry FIFO SHALL be a sub-module named result_skid_fifo, with a valid/ready interface on both sides.

Verification
REQ-034 Test 1: base=0, count=16, out_ready=1, memory[i]=i. Expect words 0..15 on consecutive cycles, done once, and busy falling with done.
REQ-035 Test 2: count=16 with out_ready toggling 1,0,0,1 repeatedly. Expect the same 16 words in order, stable data while stalled, and no FIFO overflow.
REQ-036 Test 3: base=1020, count=8. Expect addrO sequence 1020..1023, then 0..3.
REQ-037 Test 4: count=0. Expect done one cycle after start and no out_valid.
REQ-038 Test 5: rst asserted after 5 of 16 words. Expect out_valid=0 next cycle and no done; a following start with count=4 drains correctly.
REQ-039 Test 6: with RESULT_DRAIN_TLAST_EN defined and count=3, expect out_last high only on the third word; a start pulse issued mid-drain is ignored.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and default widths for the systolic result path.
// Holds the drain state encoding used by result_drain.
package systolic_pkg;

    localparam int DEF_RESULT_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH   = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_FLUSH,
        S_DONE
    } drain_state_t;

endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry fall-through FIFO with valid/ready on both sides.
// An arriving word passes straight to the output when the FIFO is empty.
module result_skid_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic         empty;
    logic         push;
    logic         pop;
    logic         store;
    logic         drop;

    assign empty     = cnt_q == 2'd0;
    assign in_ready  = cnt_q != 2'd2;
    assign out_valid = !empty || in_valid;
    assign out_data  = empty ? in_data : mem_q[rd_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // A word consumed in its arrival cycle is never stored.
    assign store     = push && !(empty && pop);
    assign drop      = pop && !empty;
    assign count     = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (store) begin
                mem_q[wr_q] <= in_data;
                wr_q        <= !wr_q;
            end
            if (drop) begin
                rd_q <= !rd_q;
            end
            cnt_q <= cnt_q + {1'b0, store} - {1'b0, drop};
        end
    end

endmodule

// File: rtl/result_drain.sv
// Streams a block of result memory out over valid/ready.
// Define RESULT_DRAIN_TLAST_EN to add out_last on the final word.
module result_drain
    import systolic_pkg::*;
#(
    parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [ADDR_WIDTH:0]     word_count,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   addrO,
    input  logic [RESULT_WIDTH-1:0] dataO,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RESULT_WIDTH-1:0] out_data
`ifdef RESULT_DRAIN_TLAST_EN
    ,
    output logic                    out_last
`endif
);

    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    drain_state_t            state_q;
    drain_state_t            state_d;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   issue_addr;
    logic [ADDR_WIDTH:0]     count_q;
    logic [ADDR_WIDTH:0]     issued_q;
    logic                    inflight_q;
    logic                    all_issued;
    logic                    credit_ok;
    logic                    issue;
    logic                    fifo_valid;
    logic                    fifo_in_ready;
    logic [RESULT_WIDTH-1:0] fifo_data;
    logic [1:0]              fifo_count;

    assign all_issued = issued_q == count_q;
    // Occupancy plus in-flight reads must stay below two.
    assign credit_ok  = fifo_in_ready &&
                        (fifo_count == 2'd0 || !inflight_q);
    assign issue      = !rst && state_q == S_READ &&
                        !all_issued && credit_ok;
    assign issue_addr = base_q + issued_q[ADDR_WIDTH-1:0];

    assign addrO     = rst ? '0 : (issue ? issue_addr : addr_q);
    assign out_valid = !rst && fifo_valid;
    assign out_data  = rst ? '0 : fifo_data;

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (word_count == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                busy = !rst;
                if (all_issued) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy = !rst;
                if (fifo_count == 2'd0 && !inflight_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = !rst;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (issue) begin
                addr_q   <= issue_addr;
                issued_q <= issued_q + ONE;
            end
            if (state_q == S_IDLE && start) begin
                base_q   <= base_addr;
                count_q  <= word_count;
                issued_q <= '0;
            end
        end
    end

    result_skid_fifo #(
        .W(RESULT_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (inflight_q),
        .in_ready (fifo_in_ready),
        .in_data  (dataO),
        .out_valid(fifo_valid),
        .out_ready(out_ready),
        .out_data (fifo_data),
        .count    (fifo_count)
    );

`ifdef RESULT_DRAIN_TLAST_EN
    logic [ADDR_WIDTH:0] sent_q;

    always_ff @(posedge clk) begin
        if (rst || state_q == S_IDLE) begin
            sent_q <= '0;
        end else if (out_valid && out_ready) begin
            sent_q <= sent_q + ONE;
        end
    end

    assign out_last = out_valid && (sent_q + ONE == count_q);
`endif

endmodule
